// File: rtl/timer_counter_pkg.sv
// Shared definitions for the TC1/TC2 countdown timer: register offsets,
// FSM state encoding, MODE codes and CTRL field positions.
package timer_counter_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  localparam int CTRL_W        = 4;
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // Only MODE=01 reloads; the reserved codes 1x fall back to one-shot.
  function automatic logic is_auto_reload(input logic [CTRL_W-1:0] ctrl);
    return (ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_AUTO);
  endfunction

  // PRESET of 0 or 1 both expire on the first counting cycle.
  function automatic logic count_expires(input logic [31:0] count);
    return (count <= 32'd1);
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, a four-state
// countdown FSM and a maskable expiry interrupt toward CP0.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000,
  parameter int          DW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [29:0]   Addr,
  input  logic          WE,
  input  logic [DW-1:0] Din,
  output logic [DW-1:0] Dout,
  output logic          IRQ
);

  logic [CTRL_W-1:0] ctrl_r;
  logic [DW-1:0]     preset_r;
  logic [DW-1:0]     count_r;
  state_t            state_r;
  logic              irq_flag_r;

  logic [1:0]        offset_s;
  logic              ctrl_we_s;
  logic              preset_we_s;
  logic              unused_addr_s;

  // Addr[1:0] here is bus address bit [3:2]; the upper word bits are decoded by the bridge.
  assign offset_s      = Addr[1:0];
  assign unused_addr_s = ^Addr[29:2];

  // Register write strobes; COUNT and the reserved slot have none.
  always_comb begin
    ctrl_we_s   = 1'b0;
    preset_we_s = 1'b0;
    if (WE) begin
      ctrl_we_s   = (offset_s == OFF_CTRL);
      preset_we_s = (offset_s == OFF_PRESET);
    end else begin
      ctrl_we_s   = 1'b0;
      preset_we_s = 1'b0;
    end
  end

  // Register file, countdown FSM and interrupt flag; the CTRL write is applied last so it overrides the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_r     <= {CTRL_W{1'b0}};
      preset_r   <= PRESET_RST;
      count_r    <= {DW{1'b0}};
      state_r    <= ST_IDLE;
      irq_flag_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ctrl_r[CTRL_EN_BIT]) begin
            state_r    <= ST_LOAD;
            irq_flag_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          count_r <= preset_r;
          state_r <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl_r[CTRL_EN_BIT]) begin
            state_r <= ST_IDLE;
          end else if (!count_expires(count_r)) begin
            count_r <= count_r - 32'd1;
          end else begin
            count_r    <= {DW{1'b0}};
            irq_flag_r <= 1'b1;
            state_r    <= ST_INT;
          end
        end
        ST_INT: begin
          state_r <= ST_IDLE;
          if (!is_auto_reload(ctrl_r)) begin
            ctrl_r[CTRL_EN_BIT] <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      if (preset_we_s) begin
        preset_r <= Din;
      end
      if (ctrl_we_s) begin
        ctrl_r     <= Din[CTRL_W-1:0];
        irq_flag_r <= 1'b0;
      end
    end
  end

  // Read mux and masked interrupt, both straight from registers.
  always_comb begin
    Dout = {DW{1'b0}};
    case (offset_s)
      OFF_CTRL:   Dout = {{(DW-CTRL_W){1'b0}}, ctrl_r};
      OFF_PRESET: Dout = preset_r;
      OFF_COUNT:  Dout = count_r;
      OFF_RSVD:   Dout = {DW{1'b0}};
      default:    Dout = {DW{1'b0}};
    endcase
    IRQ = ctrl_r[CTRL_IM_BIT] & irq_flag_r;
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter with a timeline-based reference model
// compared against Dout/IRQ on every falling clock edge.
module tb_timer_counter;
  import timer_counter_pkg::*;

  localparam logic [31:0] PRESET_RST = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_cmp = 0;
  int n_bad = 0;

  timer_counter #(.PRESET_RST(PRESET_RST), .DW(32)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout), .IRQ(IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // phase: -1 waiting for EN, 0 reload due next edge, 1..period counting edges, period+1 expired.
  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        flag;
    longint      phase;
    longint      load;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.ctrl = 4'h0; r.preset = PRESET_RST; r.count = 32'd0;
    r.flag = 1'b0; r.phase = -1; r.load = 0;
    return r;
  endfunction

  function automatic model_t model_step(model_t s, logic we, logic [1:0] off, logic [31:0] din);
    model_t n;
    longint period;
    n = s;
    period = (s.load == 0) ? 1 : s.load;
    if (s.phase < 0) begin
      if (s.ctrl[0]) begin n.phase = 0; n.flag = 1'b0; end
    end else if (s.phase == 0) begin
      n.load = longint'(s.preset); n.count = s.preset; n.phase = 1;
    end else if (s.phase <= period) begin
      if (!s.ctrl[0]) n.phase = -1;
      else if (s.phase == period) begin n.count = 32'd0; n.flag = 1'b1; n.phase = period + 1; end
      else begin n.count = 32'(s.load - s.phase); n.phase = s.phase + 1; end
    end else begin
      n.phase = -1;
      if (s.ctrl[2:1] != 2'b01) n.ctrl[0] = 1'b0;
    end
    if (we && off == 2'd0) begin n.ctrl = din[3:0]; n.flag = 1'b0; end
    if (we && off == 2'd1) n.preset = din;
    return n;
  endfunction

  function automatic logic [31:0] model_read(model_t s, logic [1:0] off);
    case (off)
      2'd0:    return {28'd0, s.ctrl};
      2'd1:    return s.preset;
      2'd2:    return s.count;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= model_reset();
    else        m <= model_step(m, WE, Addr[1:0], Din);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cycle_dout", Dout, model_read(m, Addr[1:0]));
    check("cycle_irq", {31'd0, IRQ}, {31'd0, m.ctrl[3] & m.flag});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    WE = 1'b1; Addr = {28'd0, off}; Din = d;
    step();
    WE = 1'b0; Din = 32'd0; Addr = {28'd0, OFF_COUNT};
  endtask

  task automatic rd(input logic [1:0] off, output logic [31:0] d);
    Addr = {28'd0, off};
    #1;
    d = Dout;
  endtask

  task automatic irq_edges(output int k);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (IRQ) begin k = i; break; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] seq [1:8];
    logic        irqs [1:8];
    int          exp_seq [6];
    int          k;
    logic        exp_b;

    exp_seq = '{5, 4, 3, 2, 1, 0};
    reset = 1'b0; WE = 1'b0; Addr = 30'd0; Din = 32'd0;

    // Writes while reset is held must not land.
    for (int i = 0; i < 4; i++) begin
      WE = 1'b1; Addr = 30'(i); Din = 32'hFFFF_FFFF;
      step();
      check("rst_dout", Dout, (i == 1) ? PRESET_RST : 32'd0);
      check("rst_irq", {31'd0, IRQ}, 32'd0);
    end
    WE = 1'b0; Din = 32'd0;
    step(); reset = 1'b1; step(); step();
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      check("post_rst_reg", v, (i == 1) ? PRESET_RST : 32'd0);
    end

    // One-shot, PRESET=5.
    wr(OFF_PRESET, 32'd5);
    wr(OFF_CTRL, 32'h9);
    for (int i = 1; i <= 8; i++) begin
      step();
      seq[i] = Dout; irqs[i] = IRQ;
    end
    for (int i = 0; i < 6; i++) check("oneshot_count", seq[i + 2], 32'(exp_seq[i]));
    k = 0;
    for (int i = 1; i <= 8; i++) if (irqs[i] && k == 0) k = i;
    check("oneshot_irq_edge", 32'(k), 32'd7);
    rd(OFF_CTRL, v);
    check("oneshot_ctrl", v, 32'h8);
    step(); step(); step();
    check("oneshot_irq_held", {31'd0, IRQ}, 32'd1);
    wr(OFF_CTRL, 32'h8);
    check("oneshot_irq_clr", {31'd0, IRQ}, 32'd0);
    step();
    check("oneshot_irq_clr2", {31'd0, IRQ}, 32'd0);

    // Auto-reload, PRESET=3: 6-cycle period, 2 cycles of IRQ starting at edge 5.
    wr(OFF_PRESET, 32'd3);
    wr(OFF_CTRL, 32'hB);
    for (int i = 1; i <= 24; i++) begin
      step();
      exp_b = (i >= 5) && (((i - 5) % 6) < 2);
      check("auto_irq", {31'd0, IRQ}, {31'd0, exp_b});
    end
    rd(OFF_CTRL, v);
    check("auto_ctrl", v, 32'hB);
    wr(OFF_CTRL, 32'h0);
    for (int i = 0; i < 6; i++) step();

    // Masked expiry, then a CTRL write with IM=1 clears the pending flag.
    wr(OFF_PRESET, 32'd2);
    wr(OFF_CTRL, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("mask_irq", {31'd0, IRQ}, 32'd0);
    end
    check("mask_count", Dout, 32'd0);
    wr(OFF_CTRL, 32'h8);
    for (int i = 0; i < 3; i++) begin
      check("mask_unmask_irq", {31'd0, IRQ}, 32'd0);
      step();
    end

    // Disable mid-count: the write lands on the edge that takes COUNT 7 -> 6.
    wr(OFF_PRESET, 32'd10);
    wr(OFF_CTRL, 32'h9);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (Dout == 32'd7) begin k = i; break; end
    end
    check("dis_reach7", 32'(k), 32'd5);
    wr(OFF_CTRL, 32'h8);
    for (int i = 0; i < 5; i++) begin
      step();
      check("dis_hold", Dout, 32'd6);
      check("dis_irq", {31'd0, IRQ}, 32'd0);
    end
    wr(OFF_CTRL, 32'h9);
    step(); step();
    check("dis_reload", Dout, 32'd10);
    wr(OFF_CTRL, 32'h0);
    step();

    // Writes to COUNT and the reserved slot are ignored.
    wr(OFF_COUNT, 32'h0000_1234);
    wr(OFF_RSVD, 32'hFFFF_FFFF);
    rd(OFF_CTRL, v);   check("ro_ctrl", v, 32'h0);
    rd(OFF_PRESET, v); check("ro_preset", v, 32'd10);
    rd(OFF_COUNT, v);  check("ro_count", v, 32'd9);
    rd(OFF_RSVD, v);   check("ro_rsvd", v, 32'd0);

    // PRESET=0 behaves like PRESET=1.
    wr(OFF_PRESET, 32'd0);
    wr(OFF_CTRL, 32'h9);
    irq_edges(k);
    check("p0_irq_edge", 32'(k), 32'd3);
    wr(OFF_CTRL, 32'h0);
    step();

    // Asynchronous reset in the middle of a countdown.
    wr(OFF_PRESET, 32'd20);
    wr(OFF_CTRL, 32'h9);
    for (int i = 0; i < 5; i++) step();
    rd(OFF_COUNT, v);
    check("arst_pre_count", v, 32'd17);
    reset = 1'b0;
    #1;
    check("arst_count", Dout, 32'd0);
    check("arst_irq", {31'd0, IRQ}, 32'd0);
    rd(OFF_CTRL, v);   check("arst_ctrl", v, 32'h0);
    rd(OFF_PRESET, v); check("arst_preset", v, PRESET_RST);
    step(); step();
    reset = 1'b1;
    Addr = {28'd0, OFF_COUNT};
    for (int i = 0; i < 4; i++) step();
    check("arst_after_count", Dout, 32'd0);
    check("arst_after_irq", {31'd0, IRQ}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
